// File: rtl/ps2_key_rx_if.sv
// Keyboard-side bundle for ps2_key_rx: raw PS/2 lines in, decoded key reports out.
interface ps2_key_rx_if;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [4:0] KEY;
  logic       WRITE;
  logic       FRAME_ERR;

  modport master (
    output PS2_CLK,
    output PS2_DATA,
    input  KEY,
    input  WRITE,
    input  FRAME_ERR
  );

  modport slave (
    input  PS2_CLK,
    input  PS2_DATA,
    output KEY,
    output WRITE,
    output FRAME_ERR
  );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames set-2 scan codes and reports mapped make codes as KEY/WRITE.
// Optional odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic          CLK,
  input  logic          RST,
  ps2_key_rx_if.slave   bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e             r_state, w_state_d;
  logic [1:0]         r_clk_sync, r_data_sync;
  logic               r_clk_last;
  logic [7:0]         r_shift, w_shift_d;
  logic [2:0]         r_bit_cnt, w_bit_cnt_d;
  logic               r_parity, w_parity_d;
  logic [CntW-1:0]    r_timeout_cnt, w_timeout_cnt_d;
  logic               r_break, w_break_d;
  logic               r_ext, w_ext_d;
  logic [4:0]         r_key, w_key_d;
  logic               r_write, w_write_d;
  logic               r_frame_err, w_frame_err_d;

  logic               w_fall;
  logic               w_data;
  logic [CntW-1:0]    w_cnt_inc;
  logic               w_parity_ok;
  logic [5:0]         w_lookup;

  assign w_fall    = r_clk_last & ~r_clk_sync[1];
  assign w_data    = r_data_sync[1];
  assign w_cnt_inc = r_timeout_cnt + CntW'(1);

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  assign w_parity_ok = ^{r_shift, r_parity};
`else
  assign w_parity_ok = 1'b1;
`endif

  // Returns {mapped, key} for a completed scan code.
  function automatic logic [5:0] key_lookup(input logic [7:0] code);
    logic [5:0] res;
    res = 6'd0;
    case (code)
      8'h45: res = {1'b1, 5'd0};
      8'h16: res = {1'b1, 5'd1};
      8'h1E: res = {1'b1, 5'd2};
      8'h26: res = {1'b1, 5'd3};
      8'h25: res = {1'b1, 5'd4};
      8'h2E: res = {1'b1, 5'd5};
      8'h36: res = {1'b1, 5'd6};
      8'h3D: res = {1'b1, 5'd7};
      8'h3E: res = {1'b1, 5'd8};
      8'h46: res = {1'b1, 5'd9};
      8'h1C: res = {1'b1, 5'd10};
      8'h32: res = {1'b1, 5'd11};
      8'h21: res = {1'b1, 5'd12};
      8'h23: res = {1'b1, 5'd13};
      8'h24: res = {1'b1, 5'd14};
      8'h2B: res = {1'b1, 5'd15};
      8'h5A: res = {1'b1, 5'd16};
      8'h66: res = {1'b1, 5'd17};
      8'h29: res = {1'b1, 5'd18};
      default: res = 6'd0;
    endcase
    return res;
  endfunction

  assign w_lookup = key_lookup(r_shift);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_clk_sync    <= 2'b11;
      r_data_sync   <= 2'b11;
      r_clk_last    <= 1'b1;
      r_state       <= StIdle;
      r_shift       <= 8'd0;
      r_bit_cnt     <= 3'd0;
      r_parity      <= 1'b0;
      r_timeout_cnt <= '0;
      r_break       <= 1'b0;
      r_ext         <= 1'b0;
      r_key         <= 5'd0;
      r_write       <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_clk_sync    <= {r_clk_sync[0], bus.PS2_CLK};
      r_data_sync   <= {r_data_sync[0], bus.PS2_DATA};
      r_clk_last    <= r_clk_sync[1];
      r_state       <= w_state_d;
      r_shift       <= w_shift_d;
      r_bit_cnt     <= w_bit_cnt_d;
      r_parity      <= w_parity_d;
      r_timeout_cnt <= w_timeout_cnt_d;
      r_break       <= w_break_d;
      r_ext         <= w_ext_d;
      r_key         <= w_key_d;
      r_write       <= w_write_d;
      r_frame_err   <= w_frame_err_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_shift_d       = r_shift;
    w_bit_cnt_d     = r_bit_cnt;
    w_parity_d      = r_parity;
    w_timeout_cnt_d = r_timeout_cnt;
    w_break_d       = r_break;
    w_ext_d         = r_ext;
    w_key_d         = r_key;
    w_write_d       = 1'b0;
    w_frame_err_d   = 1'b0;

    if (r_state == StIdle || w_fall) begin
      w_timeout_cnt_d = '0;
    end else begin
      w_timeout_cnt_d = w_cnt_inc;
    end

    unique case (r_state)
      StIdle: begin
        if (w_fall && !w_data) begin
          w_state_d   = StData;
          w_bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (w_fall) begin
          w_shift_d   = {w_data, r_shift[7:1]};
          w_bit_cnt_d = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_d = StParity;
          end
        end
      end
      StParity: begin
        if (w_fall) begin
          w_parity_d = w_data;
          w_state_d  = StStop;
        end
      end
      StStop: begin
        if (w_fall) begin
          w_state_d = StIdle;
          if (!w_data || !w_parity_ok) begin
            w_frame_err_d = 1'b1;
          end else if (r_shift == 8'hF0) begin
            w_break_d = 1'b1;
          end else if (r_shift == 8'hE0) begin
            w_ext_d = 1'b1;
          end else begin
            if (!r_break && !r_ext && w_lookup[5]) begin
              w_key_d   = w_lookup[4:0];
              w_write_d = 1'b1;
            end
            w_break_d = 1'b0;
            w_ext_d   = 1'b0;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Edge in the same cycle keeps the frame alive (w_fall gates the abort).
    if (r_state != StIdle && !w_fall && w_cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
      w_state_d       = StIdle;
      w_frame_err_d   = 1'b1;
      w_timeout_cnt_d = '0;
    end
  end

  assign bus.KEY       = r_key;
  assign bus.WRITE     = r_write;
  assign bus.FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Self-checking bench for ps2_key_rx: vector table of frames plus timeout and reset sequences.
module tb_ps2_key_rx;

  localparam int unsigned Timeout = 300;

  logic CLK;
  logic RST;

  ps2_key_rx_if bus ();

  ps2_key_rx #(
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       is_err;
    logic [4:0] key;
  } ev_t;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_wr;
    logic [4:0] exp_key;
    logic       exp_err;
  } vec_t;

  ev_t        exp_q[$];
  vec_t       vecs[14];
  int         n_cmp;
  int         n_err;
  logic [4:0] key_hold;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge CLK);
    bus.PS2_DATA = b;
    repeat (4) @(negedge CLK);
    bus.PS2_CLK = 1'b0;
    repeat (8) @(negedge CLK);
    bus.PS2_CLK = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
  endtask

  task automatic expect_write(input logic [4:0] k);
    ev_t e;
    e.is_err = 1'b0;
    e.key    = k;
    exp_q.push_back(e);
    key_hold = k;
  endtask

  task automatic expect_err();
    ev_t e;
    e.is_err = 1'b1;
    e.key    = 5'd0;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 60) begin
      @(negedge CLK);
      waited++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    key_hold     = 5'd0;
    bus.PS2_CLK  = 1'b1;
    bus.PS2_DATA = 1'b1;
    RST          = 1'b1;

    vecs[0]  = '{8'h16, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0};
    vecs[1]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0};
    vecs[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0};
    vecs[3]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0};
    vecs[4]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0};
    vecs[5]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0};
    vecs[6]  = '{8'h5A, 1'b0, 1'b0, 1'b1, 5'd16, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
    vecs[7]  = '{8'h45, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1};
`else
    vecs[7]  = '{8'h45, 1'b1, 1'b0, 1'b1, 5'd0,  1'b0};
`endif
    vecs[8]  = '{8'h29, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1};
    vecs[9]  = '{8'h77, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0};
    vecs[10] = '{8'h2B, 1'b0, 1'b0, 1'b1, 5'd15, 1'b0};
    vecs[11] = '{8'h3D, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0};
    vecs[12] = '{8'h66, 1'b0, 1'b0, 1'b1, 5'd17, 1'b0};
    vecs[13] = '{8'h1E, 1'b0, 1'b0, 1'b1, 5'd2,  1'b0};

    // Scoreboard monitor: every WRITE/FRAME_ERR pulse must match the queue head.
    fork
      forever begin
        @(negedge CLK);
        if (bus.WRITE || bus.FRAME_ERR) begin
          check("pulse_exclusive", int'(bus.WRITE & bus.FRAME_ERR), 0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pulse: got WRITE=%0b FRAME_ERR=%0b KEY=%0d, required none",
                     bus.WRITE, bus.FRAME_ERR, bus.KEY);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("event_kind", int'(bus.FRAME_ERR), int'(e.is_err));
            if (!e.is_err) check("event_key", int'(bus.KEY), int'(e.key));
          end
        end
      end
    join_none

    repeat (4) @(negedge CLK);
    check("reset_key", int'(bus.KEY), 0);
    check("reset_write", int'(bus.WRITE), 0);
    check("reset_err", int'(bus.FRAME_ERR), 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].exp_wr) expect_write(vecs[i].exp_key);
      if (vecs[i].exp_err) expect_err();
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
      drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_key_hold", i), int'(bus.KEY), int'(key_hold));
    end

    // Clock stalls after 4 data bits: frame abandoned by timeout.
    expect_err();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (Timeout + 20) @(negedge CLK);
    drain("timeout_drain");
    expect_write(5'd18);
    send_frame(8'h29, 1'b0, 1'b0);
    drain("after_timeout_drain");
    check("after_timeout_key", int'(bus.KEY), 18);

    // Reset during bit 5 with the PS/2 clock held low.
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    @(negedge CLK);
    bus.PS2_DATA = 1'b1;
    repeat (4) @(negedge CLK);
    bus.PS2_CLK = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    bus.PS2_CLK  = 1'b1;
    bus.PS2_DATA = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    key_hold = 5'd0;
    @(negedge CLK);
    check("mid_reset_key", int'(bus.KEY), 0);
    repeat (Timeout + 20) @(negedge CLK);
    drain("mid_reset_drain");
    expect_write(5'd17);
    send_frame(8'h66, 1'b0, 1'b0);
    drain("after_reset_drain");
    check("after_reset_key", int'(bus.KEY), 17);

    repeat (10) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000, CLK cycles without a PS2_CLK falling edge before a partial frame is abandoned (1 ms at 50 MHz).
REQ-002 Port: CLK  input  1  system clock; all logic on rising edge.
REQ-003 Port: RST  input  1  synchronous, active-high reset.
REQ-004 Port: PS2_CLK  input  1  raw keyboard clock, asynchronous to CLK.
REQ-005 Port: PS2_DATA  input  1  raw keyboard data, asynchronous to CLK.
REQ-006 Port: KEY  output  5  last reported key code; held until the next report.
REQ-007 Port: WRITE  output  1  single-cycle pulse; KEY is valid and new in that cycle.
REQ-008 Port: FRAME_ERR  output  1  single-cycle pulse on a discarded frame.

Function
REQ-009 PS2_CLK and PS2_DATA SHALL each pass through a 2-flop synchronizer; a falling edge is the synchronized PS2_CLK going 1 -> 0 between consecutive CLK cycles.
REQ-010 All frame bits SHALL be sampled from synchronized PS2_DATA in the cycle the falling edge is detected.
REQ-011 The frame FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: on a falling edge with data=0 (start bit), go to DATA; data=1 stays IDLE with no error.
REQ-013 DATA: shift in 8 bits LSB first; after the 8th bit, go to PARITY.
REQ-014 PARITY: capture the parity bit; go to STOP.
REQ-015 STOP: on the falling edge, data=1 completes the frame; data=0 discards it with FRAME_ERR; either way return to IDLE.
REQ-016 Outside IDLE, a counter SHALL count cycles since the last falling edge; on reaching TIMEOUT_CYCLES the FSM returns to IDLE, the partial frame is dropped, and FRAME_ERR pulses.
REQ-017 Completed byte 0xF0 SHALL set a break flag; 0xE0 SHALL set an extended flag; neither produces WRITE.
REQ-018 Any other completed byte SHALL clear both flags after it is processed.
REQ-019 That byte SHALL be reported only if both flags were clear and it maps in the key table; otherwise it is silently dropped.
REQ-020 Key table (set 2 scan code -> KEY):
- 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9
- 1C->10, 32->11, 21->12, 23->13, 24->14, 2B->15
- 5A->16 (Enter), 66->17 (Backspace), 29->18 (Space)
- All other codes unmapped.
REQ-021 A report SHALL update KEY and pulse WRITE for exactly one cycle, the cycle after the stop-bit falling edge is detected.
REQ-022 Back-to-back frames SHALL all be processed with no minimum gap beyond PS/2 protocol timing.
REQ-023 A timeout and a falling edge in the same cycle: the edge wins and the counter clears.

Reset
REQ-024 While RST=1 (and in the cycle after it deasserts, per the synchronous reset), outputs and state SHALL be:
- FSM IDLE; shift register, bit counter, timeout counter, break flag and extended flag 0.
- KEY=5'd0, WRITE=0, FRAME_ERR=0.
- Synchronizer flops = 1.
REQ-025 RST asserted mid-frame SHALL abandon the frame without WRITE or FRAME_ERR.

Configuration
REQ-026 With macro PS2_PARITY_CHECK_EN defined, a frame whose 8 data bits plus parity bit have even count of ones SHALL be discarded with FRAME_ERR (no report, flags unchanged).
REQ-027 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be captured and ignored.

Verification
REQ-028 Frame 0x16, odd parity, stop=1 -> one WRITE pulse with KEY=5'd1; FRAME_ERR stays 0.
REQ-029 Sequence 0x1C, F0, 1C -> exactly one WRITE with KEY=5'd10; the release produces none.
REQ-030 Sequence E0, 5A -> no WRITE; a following 5A -> WRITE with KEY=5'd16.
REQ-031 Frame 0x45 with wrong parity -> FRAME_ERR pulse and no WRITE when PS2_PARITY_CHECK_EN is defined; WRITE with KEY=5'd0 when it is not.
REQ-032 Stop PS2_CLK after 4 data bits for TIMEOUT_CYCLES -> FRAME_ERR pulse; a following clean 0x29 frame -> WRITE with KEY=5'd18.
REQ-033 Assert RST during bit 5 of a frame -> no WRITE/FRAME_ERR, KEY=0; the next clean 0x66 frame -> KEY=5'd17.
